// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding
// imem request at a time over req/gnt/rvalid, and hands each fetched
// instruction to IF/ID through a one-entry valid/ready output register.
//
// state | meaning
// IDLE  | no request outstanding; issues when allowed
// REQ   | imem_req_o high, address held until gnt
// WAIT  | request granted, waiting for rvalid
module inst_fetch #(
  parameter int                     InstAddrBus = 32,
  parameter int                     InstBus     = 32,
  parameter logic [InstAddrBus-1:0] ResetPc     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  output logic                   if_valid_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o,
  input  logic                   if_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [InstAddrBus-1:0]   r_fetch_pc;
  logic [InstAddrBus-1:0]   r_req_addr;
  logic                     r_kill;
  logic                     r_if_valid;
  logic [InstAddrBus-1:0]   r_if_pc;
  logic [InstBus-1:0]       r_if_inst;

  logic                     w_issue;
  logic                     w_resp;
  logic                     w_write;
  logic                     w_kill_set;

  // A new fetch may start only when nothing blocks it and the output
  // register has room (empty, or being drained this cycle).
  assign w_issue    = !stall_i && !branch_flag_i && (!r_if_valid || if_ready_i);
  assign w_resp     = (r_state == S_WAIT) && imem_rvalid_i;
  // A response is stale if a redirect arrived earlier (kill) or arrives now.
  assign w_write    = w_resp && !r_kill && !branch_flag_i;
  // A redirect while a fetch is still in flight marks that fetch for discard;
  // a redirect coinciding with rvalid discards directly, no kill needed.
  assign w_kill_set = branch_flag_i &&
                      ((r_state == S_REQ) || ((r_state == S_WAIT) && !imem_rvalid_i));

  assign imem_req_o  = (r_state == S_REQ);
  assign imem_addr_o = r_req_addr;
  assign if_valid_o  = r_if_valid;
  assign if_pc_o     = r_if_pc;
  assign if_inst_o   = r_if_inst;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; REQ holds regardless of stall or redirect until gnt.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_REQ;
      S_REQ:   if (imem_gnt_i) w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC, latched request address and the stale-response kill flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= ResetPc;
      r_req_addr <= '0;
      r_kill     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_issue)
        r_req_addr <= r_fetch_pc;

      if (branch_flag_i)
        r_fetch_pc <= branch_target_i;
      else if (w_write)
        r_fetch_pc <= r_req_addr + InstAddrBus'(4);

      if (w_kill_set)
        r_kill <= 1'b1;
      else if (w_resp)
        r_kill <= 1'b0;
    end
  end

  // Output register: load on a live response, flush on redirect, drain on ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
    end else begin
      if (w_write) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_req_addr;
        r_if_inst  <= imem_rdata_i;
      end else if (branch_flag_i) begin
        r_if_valid <= 1'b0;
      end else if (r_if_valid && if_ready_i) begin
        r_if_valid <= 1'b0;
      end
    end
  end

endmodule
